// File: rtl/spmv_mem_responder_if.sv
// Bundles the PE request/response signals and the backing-memory command/return
// signals of the SpMV memory responder. The responder connects through the slave
// modport; the PE/memory environment uses the master modport.
interface spmv_mem_responder_if;
  logic        req_mem_ld;
  logic        req_mem_st;
  logic [47:0] req_mem_addr;
  logic [63:0] req_mem_d_or_tag;
  logic        req_mem_stall;
  logic        rsp_mem_push;
  logic [2:0]  rsp_mem_tag;
  logic [63:0] rsp_mem_q;
  logic        rsp_mem_stall;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [47:0] mem_addr;
  logic [63:0] mem_wd;
  logic        mem_stall;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_data;
  logic        idle;
  logic        err;

  modport slave (
    input  req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
    input  rsp_mem_stall, mem_stall, mem_rd_valid, mem_rd_data,
    output req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wd, idle, err
  );

  modport master (
    output req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
    output rsp_mem_stall, mem_stall, mem_rd_valid, mem_rd_data,
    input  req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wd, idle, err
  );
endinterface

// File: rtl/spmv_mem_responder.sv
// SpMV memory responder: registers PE loads/stores into backing-memory commands,
// remembers load tags in order, pairs returning read data with its tag and
// pushes tagged responses back to the PE with back-pressure in both directions.
module spmv_mem_responder #(
  parameter int DEPTH = 16,
  parameter int SLACK = 2
) (
  input logic clk,
  input logic rst_n,
  spmv_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - SLACK);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  // Pointers carry one extra wrap bit so equal pointers mean empty.
  logic [AW:0] tag_wp, tag_rp, rsp_wp, rsp_rp;
  logic [AW:0] cnt, cnt_next;
  logic        stall_q;
  logic [2:0]  tag_mem [DEPTH];
  logic [66:0] rsp_mem [DEPTH];

  logic ld_req, ld_acc, tag_empty, rd_ok, rsp_empty, push_fire, rsp_wr, rsp_pop, err_set;

  // Request decode, FIFO status, response selection and load accounting.
  always_comb begin
    ld_req    = bus.req_mem_ld & ~bus.req_mem_st;
    ld_acc    = ld_req & (cnt != CNT_FULL);
    tag_empty = (tag_wp == tag_rp);
    rd_ok     = bus.mem_rd_valid & ~tag_empty;
    rsp_empty = (rsp_wp == rsp_rp);
    push_fire = ~bus.rsp_mem_stall & (~rsp_empty | rd_ok);
    rsp_wr    = rd_ok & (~rsp_empty | bus.rsp_mem_stall);
    rsp_pop   = ~bus.rsp_mem_stall & ~rsp_empty;
    err_set   = (bus.req_mem_ld & bus.req_mem_st) |
                (ld_req & (cnt == CNT_FULL)) |
                (bus.mem_rd_valid & tag_empty);
    cnt_next  = cnt;
    if (ld_acc && !push_fire) begin
      cnt_next = cnt + CNT_ONE;
    end else if (!ld_acc && push_fire) begin
      cnt_next = cnt - CNT_ONE;
    end
  end

  assign bus.req_mem_stall = stall_q | bus.mem_stall;
  assign bus.idle          = (cnt == '0);

  // Register one memory command per cycle; a load+store collision goes out as a store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_rd_en <= 1'b0;
      bus.mem_wr_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wd    <= '0;
    end else begin
      bus.mem_rd_en <= ld_acc;
      bus.mem_wr_en <= bus.req_mem_st;
      bus.mem_addr  <= (ld_acc | bus.req_mem_st) ? bus.req_mem_addr : '0;
      bus.mem_wd    <= bus.req_mem_st ? bus.req_mem_d_or_tag : '0;
    end
  end

  // Tag and response FIFO storage; contents are meaningless until pointers cover them.
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      tag_mem[tag_wp[AW-1:0]] <= bus.req_mem_d_or_tag[2:0];
    end
    if (rsp_wr) begin
      rsp_mem[rsp_wp[AW-1:0]] <= {tag_mem[tag_rp[AW-1:0]], bus.mem_rd_data};
    end
  end

  // FIFO pointers, outstanding-load count, registered stall and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wp  <= '0;
      tag_rp  <= '0;
      rsp_wp  <= '0;
      rsp_rp  <= '0;
      cnt     <= '0;
      stall_q <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      if (ld_acc)  tag_wp <= tag_wp + CNT_ONE;
      if (rd_ok)   tag_rp <= tag_rp + CNT_ONE;
      if (rsp_wr)  rsp_wp <= rsp_wp + CNT_ONE;
      if (rsp_pop) rsp_rp <= rsp_rp + CNT_ONE;
      cnt     <= cnt_next;
      stall_q <= (cnt_next >= STALL_TH);
      if (err_set) bus.err <= 1'b1;
    end
  end

  // Response output register: oldest buffered entry first, else bypass fresh read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_mem_push <= 1'b0;
      bus.rsp_mem_tag  <= '0;
      bus.rsp_mem_q    <= '0;
    end else if (push_fire) begin
      bus.rsp_mem_push <= 1'b1;
      if (!rsp_empty) begin
        {bus.rsp_mem_tag, bus.rsp_mem_q} <= rsp_mem[rsp_rp[AW-1:0]];
      end else begin
        {bus.rsp_mem_tag, bus.rsp_mem_q} <= {tag_mem[tag_rp[AW-1:0]], bus.mem_rd_data};
      end
    end else begin
      bus.rsp_mem_push <= 1'b0;
      bus.rsp_mem_tag  <= '0;
      bus.rsp_mem_q    <= '0;
    end
  end

endmodule

// File: tb/tb_spmv_mem_responder.sv
// Self-checking bench for spmv_mem_responder: an in-order memory model with
// configurable latency, a response scoreboard, a request vector table and
// directed sequences for stall, overflow and reset corner cases.
module tb_spmv_mem_responder;
  localparam int DEPTH = 16;
  localparam int SLACK = 2;

  typedef struct packed {
    logic [2:0]  tag;
    logic [63:0] q;
  } rsp_t;

  typedef struct {
    logic [47:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        ld;
    logic        st;
    logic [47:0] addr;
    logic [63:0] d;
    logic        exp_rd;
    logic        exp_wr;
    logic [47:0] exp_addr;
    logic [63:0] exp_wd;
    logic        chk_wd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   lat = 3;
  bit   stray_req = 1'b0;
  int   push_count = 0;
  int   last_valid_cyc = -1;
  int   push_cycles[$];
  rsp_t exp_q[$];
  pend_t pend_q[$];

  spmv_mem_responder_if bus();

  spmv_mem_responder #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running clock and a cycle counter that advances on each rising edge.
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Overall time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] mem_data(logic [47:0] a);
    return (a == 48'h40) ? 64'h3FF0_0000_0000_0000 : {16'hBEEF, a};
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // In-order backing memory: records read commands and returns data after lat cycles.
  initial begin
    pend_t p;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd_en === 1'b1) pend_q.push_back('{bus.mem_addr, cyc + lat});
      if (stray_req) begin
        stray_req        = 1'b0;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 64'h1234;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = mem_data(p.addr);
        last_valid_cyc   = cyc;
      end else begin
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every push, checks quiet outputs otherwise.
  initial begin
    rsp_t e;
    logic last_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rsp_mem_push === 1'b1) begin
        push_count++;
        push_cycles.push_back(cyc);
        check_output("push_while_stalled", 64'(last_stall), 64'd0);
        if (exp_q.size() == 0) begin
          check_output("unexpected_push", 64'(bus.rsp_mem_push), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("rsp_tag", 64'(bus.rsp_mem_tag), 64'(e.tag));
          check_output("rsp_q", bus.rsp_mem_q, e.q);
        end
      end else begin
        check_output("quiet_tag_q", {61'(bus.rsp_mem_q[60:0]), bus.rsp_mem_tag} |
                     64'(bus.rsp_mem_q[63:61]), 64'd0);
      end
      last_stall = bus.rsp_mem_stall;
    end
  end

  task automatic apply_stimulus(logic ld, logic st, logic [47:0] addr, logic [63:0] d);
    @(posedge clk);
    #1;
    bus.req_mem_ld       = ld;
    bus.req_mem_st       = st;
    bus.req_mem_addr     = addr;
    bus.req_mem_d_or_tag = d;
  endtask

  task automatic clear_req();
    apply_stimulus(1'b0, 1'b0, 48'd0, 64'd0);
  endtask

  task automatic issue_load(logic [47:0] addr, logic [2:0] tag, bit accepted);
    apply_stimulus(1'b1, 1'b0, addr, {61'd0, tag});
    if (accepted) exp_q.push_back({tag, mem_data(addr)});
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0 || bus.idle !== 1'b1) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output(name, 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    pend_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Main test sequence.
  initial begin
    vec_t tbl[6];
    int   pc0;
    int   rel;

    bus.req_mem_ld = 1'b0;
    bus.req_mem_st = 1'b0;
    bus.req_mem_addr = '0;
    bus.req_mem_d_or_tag = '0;
    bus.rsp_mem_stall = 1'b0;
    bus.mem_stall = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 48'h1000, 64'd1, 1'b1, 1'b0, 48'h1000, 64'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 48'h100, 64'hDEAD, 1'b0, 1'b1, 48'h100, 64'hDEAD, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 48'h777, 64'h55, 1'b0, 1'b0, 48'h0, 64'd0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 48'h2468, 64'd6, 1'b1, 1'b0, 48'h2468, 64'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 48'hFFFF_FFFF_FFF8, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1,
               48'hFFFF_FFFF_FFF8, 64'h0123_4567_89AB_CDEF, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 48'h40, 64'd3, 1'b1, 1'b0, 48'h40, 64'd0, 1'b0};

    // Reset values while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_push", 64'(bus.rsp_mem_push), 64'd0);
    check_output("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check_output("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    check_output("rst_addr", 64'(bus.mem_addr), 64'd0);
    check_output("rst_wd", bus.mem_wd, 64'd0);
    check_output("rst_req_stall", 64'(bus.req_mem_stall), 64'd0);
    check_output("rst_idle", 64'(bus.idle), 64'd1);
    check_output("rst_err", 64'(bus.err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven request vectors.
    lat = 3;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tbl[i].ld, tbl[i].st, tbl[i].addr, tbl[i].d);
      if (tbl[i].ld && !tbl[i].st) exp_q.push_back({tbl[i].d[2:0], mem_data(tbl[i].addr)});
      clear_req();
      check_output($sformatf("vec%0d_rd_en", i), 64'(bus.mem_rd_en), 64'(tbl[i].exp_rd));
      check_output($sformatf("vec%0d_wr_en", i), 64'(bus.mem_wr_en), 64'(tbl[i].exp_wr));
      if (tbl[i].exp_rd || tbl[i].exp_wr)
        check_output($sformatf("vec%0d_addr", i), 64'(bus.mem_addr), 64'(tbl[i].exp_addr));
      if (tbl[i].chk_wd)
        check_output($sformatf("vec%0d_wd", i), bus.mem_wd, tbl[i].exp_wd);
    end
    wait_drain("vec_drain", 100);
    check_output("vec_err", 64'(bus.err), 64'd0);

    // Single load with minimum-latency bypass to the PE.
    pc0 = push_count;
    push_cycles.delete();
    issue_load(48'h40, 3'd5, 1'b1);
    clear_req();
    check_output("single_busy", 64'(bus.idle), 64'd0);
    wait_drain("single_drain", 50);
    check_output("single_pushes", 64'(push_count - pc0), 64'd1);
    check_output("single_latency", 64'(push_cycles.size() > 0 ? push_cycles[0] : -1),
                 64'(last_valid_cyc + 1));
    check_output("single_idle", 64'(bus.idle), 64'd1);

    // Eight back-to-back loads, tags 0..7, latency 10.
    lat = 10;
    pc0 = push_count;
    for (int t = 0; t < 8; t++) begin
      issue_load(48'h200 + 48'(t * 8), 3'(t), 1'b1);
      if (t > 0) check_output($sformatf("b2b_stall%0d", t), 64'(bus.req_mem_stall), 64'd0);
    end
    clear_req();
    check_output("b2b_stall8", 64'(bus.req_mem_stall), 64'd0);
    wait_drain("b2b_drain", 100);
    check_output("b2b_pushes", 64'(push_count - pc0), 64'd8);
    check_output("b2b_err", 64'(bus.err), 64'd0);

    // Response stall held for 20 cycles while 6 responses return.
    lat = 2;
    pc0 = push_count;
    @(posedge clk);
    #1;
    bus.rsp_mem_stall = 1'b1;
    for (int t = 0; t < 6; t++) issue_load(48'h400 + 48'(t * 8), 3'(t + 2), 1'b1);
    clear_req();
    repeat (13) @(posedge clk);
    #1;
    check_output("stall_no_push", 64'(push_count - pc0), 64'd0);
    push_cycles.delete();
    bus.rsp_mem_stall = 1'b0;
    rel = cyc;
    wait_drain("stall_drain", 50);
    check_output("stall_pushes", 64'(push_cycles.size()), 64'd6);
    if (push_cycles.size() == 6) begin
      check_output("stall_first", 64'(push_cycles[0]), 64'(rel + 1));
      check_output("stall_span", 64'(push_cycles[5] - push_cycles[0]), 64'd5);
    end

    // Store: command only, no response and no outstanding count.
    pc0 = push_count;
    apply_stimulus(1'b0, 1'b1, 48'h100, 64'hDEAD);
    clear_req();
    check_output("store_wr_en", 64'(bus.mem_wr_en), 64'd1);
    check_output("store_addr", 64'(bus.mem_addr), 64'h100);
    check_output("store_wd", bus.mem_wd, 64'hDEAD);
    check_output("store_idle", 64'(bus.idle), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check_output("store_no_push", 64'(push_count - pc0), 64'd0);

    // Memory back-pressure reaches the PE combinationally.
    bus.mem_stall = 1'b1;
    #1;
    check_output("mem_stall_on", 64'(bus.req_mem_stall), 64'd1);
    bus.mem_stall = 1'b0;
    #1;
    check_output("mem_stall_off", 64'(bus.req_mem_stall), 64'd0);

    // Load and store together: treated as a store and flagged.
    apply_stimulus(1'b1, 1'b1, 48'h300, 64'hCAFE);
    clear_req();
    check_output("both_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check_output("both_wr_en", 64'(bus.mem_wr_en), 64'd1);
    check_output("both_wd", bus.mem_wd, 64'hCAFE);
    check_output("both_err", 64'(bus.err), 64'd1);
    check_output("both_idle", 64'(bus.idle), 64'd1);
    do_reset();
    @(posedge clk);
    #1;
    check_output("reset_clears_err", 64'(bus.err), 64'd0);

    // Seventeen loads ignoring stall: 16 accepted, the 17th dropped with err.
    lat = 60;
    pc0 = push_count;
    for (int k = 1; k <= 17; k++) begin
      issue_load(48'h800 + 48'(k * 8), 3'(k), k <= DEPTH);
      clear_req();
      check_output($sformatf("ovf_rd_en%0d", k), 64'(bus.mem_rd_en), 64'(k <= DEPTH));
      check_output($sformatf("ovf_stall%0d", k), 64'(bus.req_mem_stall), 64'(k >= DEPTH - SLACK));
      check_output($sformatf("ovf_err%0d", k), 64'(bus.err), 64'(k > DEPTH));
    end
    wait_drain("ovf_drain", 300);
    check_output("ovf_pushes", 64'(push_count - pc0), 64'd16);
    check_output("ovf_err_sticky", 64'(bus.err), 64'd1);
    check_output("ovf_stall_release", 64'(bus.req_mem_stall), 64'd0);
    do_reset();

    // Asynchronous reset with three loads outstanding, then a stray return.
    lat = 30;
    issue_load(48'h900, 3'd1, 1'b1);
    issue_load(48'h908, 3'd2, 1'b1);
    issue_load(48'h910, 3'd3, 1'b1);
    @(posedge clk);
    #2;
    check_output("pre_rst_rd_en", 64'(bus.mem_rd_en), 64'd1);
    check_output("pre_rst_idle", 64'(bus.idle), 64'd0);
    rst_n = 1'b0;
    bus.req_mem_ld = 1'b0;
    exp_q.delete();
    pend_q.delete();
    #1;
    check_output("async_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check_output("async_addr", 64'(bus.mem_addr), 64'd0);
    check_output("async_idle", 64'(bus.idle), 64'd1);
    check_output("async_stall", 64'(bus.req_mem_stall), 64'd0);
    pend_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("post_rst_err", 64'(bus.err), 64'd0);
    pc0 = push_count;
    stray_req = 1'b1;
    @(posedge clk);
    #1;
    check_output("stray_err", 64'(bus.err), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check_output("stray_no_push", 64'(push_count - pc0), 64'd0);
    check_output("stray_idle", 64'(bus.idle), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
